// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// vga_sync_decoder : locks onto raw hsync/vsync, regenerates pixel coordinates
// Revision 1.0 : initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_BACK      = 33,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines
);

  localparam logic [10:0] c_cnt_max     = 11'h7FF;
  localparam logic [10:0] c_h_start     = 11'(H_BACK);
  localparam logic [10:0] c_h_end       = 11'(H_BACK + H_ACTIVE);
  localparam logic [10:0] c_v_start     = 11'(V_BACK);
  localparam logic [10:0] c_v_end       = 11'(V_BACK + V_ACTIVE);
  localparam logic [4:0]  c_lock_frames = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_hs_q;
  logic        r_vs_q;
  logic        r_vs_pend;
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [10:0] r_line_len;
  logic [10:0] r_frame_lines;
  logic [10:0] r_line_ref;
  logic        r_ref_vld;
  logic [10:0] r_frame_ref;
  logic [3:0]  r_match_cnt;
  logic        r_locked;
  logic [9:0]  r_pixel_x;
  logic [9:0]  r_pixel_y;
  logic        r_video_on;
  logic        r_frame_start;

  logic [10:0] w_line_ref_nxt;
  logic        w_ref_vld_nxt;
  logic [10:0] w_frame_ref_nxt;
  logic [3:0]  w_match_nxt;

  logic        w_hte;
  logic        w_vte;
  logic        w_fc;
  logic        w_hsat;
  logic [10:0] w_len;
  logic [10:0] w_frame;
  logic [4:0]  w_match_inc;
  logic        w_h_act;
  logic        w_v_act;
  logic        w_von;
  logic [9:0]  w_px;
  logic [9:0]  w_py;

  assign w_hte       = (r_hs_q == HSYNC_POL) && (hsync != HSYNC_POL);
  assign w_vte       = (r_vs_q == VSYNC_POL) && (vsync != VSYNC_POL);
  // A vsync trailing edge coinciding with the hte is consumed immediately.
  assign w_fc        = w_hte && (r_vs_pend || w_vte);
  assign w_hsat      = (r_h_cnt == c_cnt_max);
  assign w_len       = r_h_cnt + 11'd1;
  assign w_frame     = r_v_cnt + 11'd1;
  assign w_match_inc = {1'b0, r_match_cnt} + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_q        <= 1'b0;
      r_vs_q        <= 1'b0;
      r_vs_pend     <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
    end else begin
      r_hs_q <= hsync;
      r_vs_q <= vsync;
      if (w_hte) begin
        r_h_cnt    <= '0;
        r_line_len <= w_len;
      end else if (!w_hsat) begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
      if (w_fc) begin
        r_frame_lines <= w_frame;
        r_v_cnt       <= '0;
        r_vs_pend     <= 1'b0;
      end else begin
        if (w_hte && (r_v_cnt != c_cnt_max)) begin
          r_v_cnt <= r_v_cnt + 11'd1;
        end
        if (w_vte) begin
          r_vs_pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_SEARCH;
      r_line_ref  <= '0;
      r_ref_vld   <= 1'b0;
      r_frame_ref <= '0;
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_line_ref  <= w_line_ref_nxt;
      r_ref_vld   <= w_ref_vld_nxt;
      r_frame_ref <= w_frame_ref_nxt;
      r_match_cnt <= w_match_nxt;
      r_locked    <= (w_state_nxt == S_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_line_ref_nxt  = r_line_ref;
    w_ref_vld_nxt   = r_ref_vld;
    w_frame_ref_nxt = r_frame_ref;
    w_match_nxt     = r_match_cnt;
    case (r_state)
      S_SEARCH: begin
        if (w_fc) begin
          w_state_nxt    = S_MEASURE;
          w_match_nxt    = '0;
          w_line_ref_nxt = '0;
          w_ref_vld_nxt  = 1'b0;
        end
      end
      S_MEASURE: begin
        if (w_hsat || (w_hte && r_ref_vld && (w_len != r_line_ref))) begin
          w_state_nxt = S_SEARCH;
        end else begin
          if (w_hte && !r_ref_vld) begin
            w_line_ref_nxt = w_len;
            w_ref_vld_nxt  = 1'b1;
          end
          if (w_fc) begin
            if ((r_match_cnt == 4'd0) || (w_frame == r_frame_ref)) begin
              w_frame_ref_nxt = w_frame;
              w_match_nxt     = w_match_inc[3:0];
              if (w_match_inc >= c_lock_frames) begin
                w_state_nxt = S_LOCKED;
              end
            end else begin
              w_state_nxt = S_SEARCH;
            end
          end
        end
      end
      S_LOCKED: begin
        if (w_hsat || (w_hte && (w_len != r_line_ref)) ||
            (w_fc && (w_frame != r_frame_ref))) begin
          w_state_nxt = S_SEARCH;
        end
      end
      default: w_state_nxt = S_SEARCH;
    endcase
  end

  // Offsets are formed at counter width; only the in-window value is kept.
  assign w_h_act = (r_h_cnt >= c_h_start) && (r_h_cnt < c_h_end);
  assign w_v_act = (r_v_cnt >= c_v_start) && (r_v_cnt < c_v_end);
  assign w_von   = w_h_act && w_v_act && (r_state == S_LOCKED);
  assign w_px    = 10'(r_h_cnt - c_h_start);
  assign w_py    = 10'(r_v_cnt - c_v_start);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_video_on    <= w_von;
      r_pixel_x     <= w_von ? w_px : 10'd0;
      r_pixel_y     <= w_von ? w_py : 10'd0;
      r_frame_start <= (r_state == S_LOCKED) && (r_h_cnt == c_h_start) &&
                       (r_v_cnt == c_v_start);
    end
  end

  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;
  assign locked      = r_locked;
  assign line_len    = r_line_len;
  assign frame_lines = r_frame_lines;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_decoder : directed bench on a scaled 24x10 raster (16x6 active)
// Revision 1.0 : initial release
// ============================================================================
module tb_vga_sync_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hsync;
  logic        vsync;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        frame_start;
  logic        locked;
  logic [10:0] line_len;
  logic [10:0] frame_lines;

  int          n_checks = 0;
  int          n_errors = 0;
  int          frame_no = 0;
  int          cur_line = 0;
  int          cur_h    = 0;
  logic        prev_locked = 1'b0;
  logic [47:0] rise_pos = '0;
  logic [47:0] fall_pos = '0;

  vga_sync_decoder #(
    .H_ACTIVE    (16),
    .H_BACK      (2),
    .V_ACTIVE    (6),
    .V_BACK      (2),
    .HSYNC_POL   (1'b0),
    .VSYNC_POL   (1'b0),
    .LOCK_FRAMES (2)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .frame_start (frame_start),
    .locked      (locked),
    .line_len    (line_len),
    .frame_lines (frame_lines)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (frame %0d line %0d h %0d)",
               tag, got, exp, frame_no, cur_line, cur_h);
    end
  endtask

  function automatic logic [47:0] mk_pos(input int f, input int l, input int h);
    return {16'(f), 16'(l), 16'(h)};
  endfunction

  // Drive one raster position, then look at the outputs it produced.
  task automatic tick(input logic hs, input logic vs);
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    @(posedge clk);
    #1;
    if (locked !== prev_locked) begin
      if (locked === 1'b1) rise_pos = mk_pos(frame_no, cur_line, cur_h);
      else                 fall_pos = mk_pos(frame_no, cur_line, cur_h);
      prev_locked = locked;
    end
  endtask

  // Line: hsync low for h 0..2, 24 clocks (25 on the stretched line).
  // Frame: vsync low on lines 0..1. Decoded pixel (0,0) lands at line 4, h 6.
  task automatic run_frame(input int nlines, input int stretch, input bit scan, input int rst_line);
    int         von_cnt;
    logic [19:0] last_xy;
    logic       ev;
    von_cnt = 0;
    last_xy = '0;
    for (int l = 0; l < nlines; l++) begin
      for (int h = 0; h < ((l == stretch) ? 25 : 24); h++) begin
        cur_line = l;
        cur_h    = h;
        if (l == rst_line && h == 1) begin
          @(negedge clk);
          reset_n = 1'b0;
          #1;
          check_eq("async_reset_outputs",
                   {pixel_x, pixel_y, video_on, frame_start, locked, line_len, frame_lines}, 64'd0);
        end
        if (l == rst_line && h == 3) reset_n = 1'b1;
        tick(h >= 3, l >= 2);
        if (scan) begin
          ev = (h >= 6) && (h < 22) && (l >= 4) && (l < 10);
          check_eq("scan_pixel",
                   {video_on, frame_start, pixel_x, pixel_y},
                   {ev, (l == 4 && h == 6), ev ? 10'(h - 6) : 10'd0, ev ? 10'(l - 4) : 10'd0});
          if (video_on === 1'b1) begin
            von_cnt++;
            last_xy = {pixel_x, pixel_y};
          end
        end
      end
    end
    if (scan) begin
      check_eq("active_count", 64'(von_cnt), 64'd96);
      check_eq("last_active_xy", {44'd0, last_xy}, {44'd0, 10'd15, 10'd5});
    end
    frame_no++;
  endtask

  initial begin
    reset_n = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs",
             {pixel_x, pixel_y, video_on, frame_start, locked, line_len, frame_lines}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Initial lock: third vsync trailing edge, at its following hte.
    run_frame(10, -1, 1'b0, -1);
    run_frame(10, -1, 1'b0, -1);
    check_eq("not_locked_early", {63'd0, locked}, 64'd0);
    run_frame(10, -1, 1'b1, -1);
    check_eq("lock_rise_pos", {16'd0, rise_pos}, {16'd0, mk_pos(2, 2, 3)});
    check_eq("line_len", {53'd0, line_len}, 64'd24);
    check_eq("frame_lines", {53'd0, frame_lines}, 64'd10);
    run_frame(10, -1, 1'b1, -1);

    // One line stretched to 25 clocks.
    run_frame(10, 5, 1'b0, -1);
    check_eq("stretch_fall_pos", {16'd0, fall_pos}, {16'd0, mk_pos(4, 6, 3)});
    check_eq("stretch_unlocked", {62'd0, locked, video_on}, 64'd0);
    run_frame(10, -1, 1'b0, -1);
    run_frame(10, -1, 1'b0, -1);
    check_eq("stretch_still_unlocked", {63'd0, locked}, 64'd0);
    run_frame(10, -1, 1'b0, -1);
    check_eq("stretch_relock_pos", {16'd0, rise_pos}, {16'd0, mk_pos(7, 2, 3)});

    // Frame height changes to 11 lines.
    run_frame(11, -1, 1'b0, -1);
    check_eq("height_still_locked", {63'd0, locked}, 64'd1);
    run_frame(11, -1, 1'b0, -1);
    check_eq("height_fall_pos", {16'd0, fall_pos}, {16'd0, mk_pos(9, 2, 3)});
    check_eq("height_frame_lines", {53'd0, frame_lines}, 64'd11);
    run_frame(11, -1, 1'b0, -1);
    run_frame(11, -1, 1'b0, -1);
    check_eq("height_still_unlocked", {63'd0, locked}, 64'd0);
    run_frame(11, -1, 1'b0, -1);
    check_eq("height_relock_pos", {16'd0, rise_pos}, {16'd0, mk_pos(12, 2, 3)});

    // hsync held inactive until the line counter saturates.
    cur_line = 99;
    for (int i = 0; i < 2100; i++) begin
      cur_h = i;
      tick(1'b1, 1'b1);
      if (i == 1499) check_eq("idle_still_locked", {63'd0, locked}, 64'd1);
    end
    check_eq("idle_unlocked", {63'd0, locked}, 64'd0);
    check_eq("idle_outputs", {41'd0, video_on, frame_start, pixel_x, pixel_y}, 64'd0);
    check_eq("idle_line_len", {53'd0, line_len}, 64'd24);
    check_eq("idle_frame_lines", {53'd0, frame_lines}, 64'd11);

    // Relock on the standard raster, then pulse reset mid-frame.
    run_frame(10, -1, 1'b0, -1);
    run_frame(10, -1, 1'b0, -1);
    run_frame(10, -1, 1'b0, -1);
    check_eq("idle_relock_pos", {16'd0, rise_pos}, {16'd0, mk_pos(15, 2, 3)});
    run_frame(10, -1, 1'b0, 1);
    check_eq("post_reset_unlocked", {63'd0, locked}, 64'd0);
    run_frame(10, -1, 1'b0, -1);
    check_eq("post_reset_still_unlocked", {63'd0, locked}, 64'd0);
    run_frame(10, -1, 1'b1, -1);
    check_eq("post_reset_relock_pos", {16'd0, rise_pos}, {16'd0, mk_pos(18, 2, 3)});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the team's VGA timing generator (horizontal/vertical counters, 800x525 totals, 640x480 active).
- Takes raw hsync/vsync, in the same pixel-clock domain, from a timing source or an upstream capture path.
- Measures line length and frame height, and declares lock once timing is stable.
- Regenerates pixel_x, pixel_y, video_on and a frame-start strobe for downstream capture/overlay logic.

Parameters:
H_ACTIVE, 640, active pixels per line
H_BACK, 48, clocks from hsync trailing edge to first active pixel
V_ACTIVE, 480, active lines per frame
V_BACK, 33, lines from vsync trailing edge to first active line
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
LOCK_FRAMES, 2, consecutive matching frames required for lock (1..15)

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, already synchronous to clk
vsync  in  1  vertical sync, already synchronous to clk
pixel_x  out  10  recovered column, 0..H_ACTIVE-1 while video_on, else 0
pixel_y  out  10  recovered row, 0..V_ACTIVE-1 while video_on, else 0
video_on  out  1  high for active pixels, only while locked
frame_start  out  1  one-cycle pulse on pixel (0,0) while locked
locked  out  1  timing lock indicator
line_len  out  11  last measured hsync period, in clocks
frame_lines  out  11  last measured frame height, in lines

Behaviour:
- Reset: all outputs 0; state SEARCH; all counters, reference registers and match_cnt 0.
- Edge detect:
  - hsync/vsync are registered once (hs_q, vs_q).
  - H trailing edge (hte): hs_q == HSYNC_POL and hsync != HSYNC_POL.
  - V trailing edge (vte): same rule using vs_q, vsync and VSYNC_POL.
- h_cnt (11 bit): loads 0 on hte, else increments. Saturates at 2047; reaching 2047 means hsync lost: go to SEARCH.
- line_len: on hte, line_len <= h_cnt + 1 (clocks between consecutive trailing edges).
- v_cnt (11 bit):
  - vte sets vs_pend.
  - On hte with vs_pend: frame_lines <= v_cnt + 1, v_cnt <= 0, clear vs_pend (this is the frame-complete event).
  - On hte without vs_pend: v_cnt increments, saturating at 2047.
  - vte and hte on the same cycle: vs_pend is set and consumed in that same cycle.
- FSM:
  - SEARCH -> MEASURE on the first frame-complete event. Clear match_cnt and line_ref.
  - MEASURE:
    - First hte latches line_ref.
    - Any later hte whose line_len != line_ref: -> SEARCH.
    - At frame complete: if match_cnt == 0 or frame_lines == frame_ref, then frame_ref <= frame_lines and match_cnt++; else -> SEARCH.
    - When match_cnt reaches LOCK_FRAMES: -> LOCKED, locked <= 1.
  - LOCKED: any line length mismatch, frame_lines mismatch, or h_cnt saturation -> SEARCH, locked <= 0 on the next clock.
- Coordinates (registered, 1-cycle latency from counters):
  - Active when H_BACK <= h_cnt < H_BACK+H_ACTIVE and V_BACK <= v_cnt < V_BACK+V_ACTIVE.
  - pixel_x = h_cnt - H_BACK; pixel_y = v_cnt - V_BACK.
  - video_on = active & LOCKED; pixel_x/pixel_y forced to 0 when video_on is 0.
  - frame_start = LOCKED & h_cnt == H_BACK & v_cnt == V_BACK.
- Arithmetic: subtractions are done at 11 bits and truncated to 10 bits only inside the active window.
- Reset asserted mid-frame: immediate return to reset state; relock requires a full SEARCH/MEASURE sequence.

Test Plan:
- Ideal 640x480 stream (800x525, hsync 96 clk active-low, vsync 2 lines) -> line_len=800, frame_lines=525. locked rises after the third vsync trailing edge (SEARCH exit, reference frame, one match). With locked, first video_on cycle has pixel_x=0, pixel_y=0, frame_start=1.
- Locked stream: check the active window -> video_on high for exactly 640x480 cycles per frame, pixel_x sweeps 0..639, last active pixel is (639,479), no frame_start elsewhere.
- Locked, then one line stretched to 801 clocks -> locked falls one clock after that hte, video_on=0; relocks after 3 more clean frames.
- Locked, then frame height changed to 526 lines -> loss of lock at frame complete, frame_lines=526; relock after the new height repeats LOCK_FRAMES frames.
- hsync held inactive for 2100 clocks -> h_cnt saturates, state SEARCH, locked=0, no X on outputs.
- reset_n pulsed low mid-frame while locked -> all outputs 0 asynchronously; after release, locked stays 0 until the full lock sequence repeats.
